// File: rtl/pipeline_pkg.sv
// Shared pipeline types: fetch FSM states, IF/ID payload and the NOP encoding.
package pipeline_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned JIDX_W = 26;

   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc4;
      logic            valid;
   } if_id_t;

   // Word-align a byte address.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter register and next-PC select (branch > jump > hold > pc+4).
module pc_unit
   import pipeline_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_boot,
   input  logic              i_stall,
   input  logic              i_branch_taken,
   input  logic [XLEN-1:0]   i_branch_target,
   input  logic              i_jump,
   input  logic [JIDX_W-1:0] i_jump_index,
   input  logic [3:0]        i_pc4_hi,
   output logic [XLEN-1:0]   o_pc,
   output logic [XLEN-1:0]   o_pc4
);

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_next;
   logic [XLEN-1:0] w_pc_inc;
   logic [XLEN-1:0] w_jump_target;

   assign w_pc_inc      = r_pc + XLEN'(4);
   assign w_jump_target = {i_pc4_hi, i_jump_index, 2'b00};

   // The boot cycle freezes the PC so the first fetch address survives one bubble.
   always_comb begin
      w_pc_next = w_pc_inc;
      if (i_boot) begin
         w_pc_next = r_pc;
      end else if (i_branch_taken) begin
         w_pc_next = i_branch_target;
      end else if (i_jump) begin
         w_pc_next = w_jump_target;
      end else if (i_stall) begin
         w_pc_next = r_pc;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc <= align_word(RESET_PC);
      end else begin
         r_pc <= align_word(w_pc_next);
      end
   end

   assign o_pc  = r_pc;
   assign o_pc4 = w_pc_inc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: boot/run/hold FSM, IF/ID register and address-range flag.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [25:0] jump_index,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        addr_oob
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] bubble_cnt
`endif
);

   fetch_state_e    r_state;
   if_id_t          r_if_id;
   logic            r_addr_oob;

   logic [XLEN-1:0] w_pc;
   logic [XLEN-1:0] w_pc4;
   logic            w_boot;
   logic            w_redirect;
   logic            w_if_id_we;
   if_id_t          w_if_id_d;

   assign w_boot     = (r_state == ST_BOOT);
   assign w_redirect = branch_taken | jump;

   pc_unit #(
      .RESET_PC (RESET_PC)
   ) u_pc_unit (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_boot          (w_boot),
      .i_stall         (stall),
      .i_branch_taken  (branch_taken),
      .i_branch_target (branch_target),
      .i_jump          (jump),
      .i_jump_index    (jump_index),
      .i_pc4_hi        (r_if_id.pc4[31:28]),
      .o_pc            (w_pc),
      .o_pc4           (w_pc4)
   );

   // Bubbles keep the previous pc4; a plain stall leaves the register untouched.
   always_comb begin
      w_if_id_we = 1'b1;
      w_if_id_d  = r_if_id;
      if (w_boot || w_redirect || flush) begin
         w_if_id_d.inst  = NOP_INST;
         w_if_id_d.valid = 1'b0;
      end else if (stall) begin
         w_if_id_we = 1'b0;
      end else begin
         w_if_id_d.inst  = imem_inst;
         w_if_id_d.pc4   = w_pc4;
         w_if_id_d.valid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_BOOT;
         r_if_id    <= '0;
         r_addr_oob <= 1'b0;
      end else begin
         r_addr_oob <= (w_pc >= XLEN'(IMEM_BYTES));
         if (w_if_id_we) begin
            r_if_id <= w_if_id_d;
         end
         case (r_state)
            ST_BOOT: r_state <= ST_RUN;
            default: r_state <= (stall && !w_redirect) ? ST_HOLD : ST_RUN;
         endcase
      end
   end

   assign imem_addr   = w_pc;
   assign if_id_inst  = r_if_id.inst;
   assign if_id_pc4   = r_if_id.pc4;
   assign if_id_valid = r_if_id.valid;
   assign addr_oob    = r_addr_oob;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_bubble_cnt;

   // Count each IF/ID write by kind; both saturate at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else if (w_if_id_we) begin
         if (w_if_id_d.valid) begin
            if (r_fetch_cnt != '1) r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end else begin
            if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 32'd1;
         end
      end
   end

   assign fetch_cnt  = r_fetch_cnt;
   assign bubble_cnt = r_bubble_cnt;
`else
   // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage; expected IF/ID and PC state come from a reference model.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [25:0] jump_index;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        addr_oob;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] bubble_cnt;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        valid;
      logic        oob;
`ifdef FETCH_PERF_CNT_EN
      logic [31:0] fcnt;
      logic [31:0] bcnt;
`endif
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_pc;
   logic [31:0] m_inst;
   logic [31:0] m_pc4;
   logic        m_valid;
   logic        m_boot;
   logic        m_oob;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] m_fcnt;
   logic [31:0] m_bcnt;
   logic [31:0] saved_bcnt;
`endif

   fetch_stage #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_BYTES (1024)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .flush         (flush),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_index    (jump_index),
      .imem_addr     (imem_addr),
      .imem_inst     (imem_inst),
      .if_id_inst    (if_id_inst),
      .if_id_pc4     (if_id_pc4),
      .if_id_valid   (if_id_valid),
      .addr_oob      (addr_oob)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt     (fetch_cnt),
      .bubble_cnt    (bubble_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'h8C00_0000;
   endfunction

   assign imem_inst = mem_f(imem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, push the model's prediction, then compare after the edge.
   task automatic step(input logic r, input logic s, input logic f, input logic b,
                       input logic [31:0] t, input logic j, input logic [25:0] ix);
      exp_t        e;
      logic        we;
      logic        oob_n;
      logic [31:0] npc;
      rst = r; stall = s; flush = f; branch_taken = b;
      branch_target = t; jump = j; jump_index = ix;
      if (r) begin
         m_pc = 32'h0; m_boot = 1'b1; m_inst = 32'h0; m_pc4 = 32'h0;
         m_valid = 1'b0; m_oob = 1'b0;
`ifdef FETCH_PERF_CNT_EN
         m_fcnt = 32'h0; m_bcnt = 32'h0;
`endif
      end else begin
         we    = 1'b1;
         oob_n = (m_pc >= 32'd1024);
         if (m_boot) begin
            npc = m_pc;
            m_inst = 32'h0; m_valid = 1'b0;
            m_boot = 1'b0;
         end else begin
            if (b)      npc = {t[31:2], 2'b00};
            else if (j) npc = {m_pc4[31:28], ix, 2'b00};
            else if (s) npc = m_pc;
            else        npc = m_pc + 32'd4;
            if (b || j || f) begin
               m_inst = 32'h0; m_valid = 1'b0;
            end else if (s) begin
               we = 1'b0;
            end else begin
               m_inst = mem_f(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            end
         end
`ifdef FETCH_PERF_CNT_EN
         if (we && m_valid && m_fcnt != 32'hFFFF_FFFF)  m_fcnt = m_fcnt + 32'd1;
         if (we && !m_valid && m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 32'd1;
`else
         we = we;
`endif
         m_pc  = npc;
         m_oob = oob_n;
      end
      e.pc = m_pc; e.inst = m_inst; e.pc4 = m_pc4; e.valid = m_valid; e.oob = m_oob;
`ifdef FETCH_PERF_CNT_EN
      e.fcnt = m_fcnt; e.bcnt = m_bcnt;
`endif
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("imem_addr",   imem_addr,   e.pc);
         check("if_id_inst",  if_id_inst,  e.inst);
         check("if_id_pc4",   if_id_pc4,   e.pc4);
         check("if_id_valid", 32'(if_id_valid), 32'(e.valid));
         check("addr_oob",    32'(addr_oob),    32'(e.oob));
`ifdef FETCH_PERF_CNT_EN
         check("fetch_cnt",   fetch_cnt,   e.fcnt);
         check("bubble_cnt",  bubble_cnt,  e.bcnt);
`endif
      end
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
      branch_target = 32'h0; jump = 1'b0; jump_index = 26'h0;

      // Reset and boot bubble
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
      check("rst_addr",  imem_addr, 32'h0);
      check("rst_valid", 32'(if_id_valid), 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
      check("boot_addr",  imem_addr, 32'h0);
      check("boot_valid", 32'(if_id_valid), 32'd0);
      run(1);
      check("first_pc4",   if_id_pc4, 32'd4);
      check("first_valid", 32'(if_id_valid), 32'd1);
      run(4);
      check("pc_at_20", imem_addr, 32'd20);

      // Two-cycle stall at pc=20
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
      check("stall_addr", imem_addr, 32'd20);
      check("stall_pc4",  if_id_pc4, 32'd20);
      check("stall_inst", if_id_inst, mem_f(32'd16));
      run(1);

      // Branch to 0x70, then unaligned branch to 0x50 to set up the jump
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h70, 1'b0, 26'h0);
      check("br_addr",  imem_addr, 32'h70);
      check("br_valid", 32'(if_id_valid), 32'd0);
      check("br_inst",  if_id_inst, 32'h0);
      run(1);
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h53, 1'b0, 26'h0);
      run(1);
      check("pre_jump_pc4", if_id_pc4, 32'd84);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 26'd22);
      check("jump_addr", imem_addr, 32'd88);
      run(2);

      // Branch and jump together under stall: branch wins
`ifdef FETCH_PERF_CNT_EN
      saved_bcnt = m_bcnt;
`endif
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 26'd7);
      check("brj_addr",  imem_addr, 32'h40);
      check("brj_valid", 32'(if_id_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
      check("brj_bubble_inc", bubble_cnt, saved_bcnt + 32'd1);
`endif
      run(2);

      // Flush during stall, then stall alone, then release
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 26'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
      run(2);

      // Address range flag around 1024
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h3F8, 1'b0, 26'h0);
      run(2);
      check("pc_1024",     imem_addr, 32'd1024);
      check("oob_before",  32'(addr_oob), 32'd0);
      run(1);
      check("oob_after",   32'(addr_oob), 32'd1);

      // pc+4 wraps at the top of the address space
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0);
      run(1);
      check("wrap_addr", imem_addr, 32'h0);
      check("wrap_pc4",  if_id_pc4, 32'h0);
      run(2);

      // Reset beats stall and redirect
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'h0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 26'd5);
      check("rst_mid_addr", imem_addr, 32'h0);
      check("rst_mid_pc4",  if_id_pc4, 32'h0);
      run(4);

      // Random traffic
      for (int k = 0; k < 80; k++) begin
         step(1'b0, ($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 10) == 0,
              $urandom & 32'h0000_07FF, ($urandom % 10) == 0, 26'($urandom_range(0, 300)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
